// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: command-frame controller behind a UART receiver.
// Hunts for a sync byte, then collects CMD, LEN, payload and an XOR checksum.
// A good frame is held until the consumer acknowledges it. Errors are reported
// as single-cycle pulses.
// Ports:
//   i_CLK, i_RST          clock, asynchronous active-high reset
//   i_DATA_RX             received byte
//   i_RX_DATA_VALID       single-cycle strobe that qualifies i_DATA_RX
//   i_FRAME_ACK           consumer releases the held frame
//   i_RD_ADDR / o_RD_DATA payload buffer read port, one cycle of latency
//   o_FRAME_VALID         a good frame is held
//   o_CMD, o_LEN          CMD and LEN of the held frame (0 when no frame is held)
//   o_ERR_CHECKSUM, o_ERR_LENGTH, o_ERR_TIMEOUT, o_OVERRUN  error pulses
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  c_SYNC_BYTE      = 8'hA5,
  parameter int unsigned c_MAX_PAYLOAD    = 8,
  parameter int unsigned c_ADDR_WIDTH     = 3,
  parameter int unsigned c_TIMEOUT_CYCLES = 4340
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [7:0]              i_DATA_RX,
  input  logic                    i_RX_DATA_VALID,
  input  logic                    i_FRAME_ACK,
  input  logic [c_ADDR_WIDTH-1:0] i_RD_ADDR,
  output logic [7:0]              o_RD_DATA,
  output logic                    o_FRAME_VALID,
  output logic [7:0]              o_CMD,
  output logic [7:0]              o_LEN,
  output logic                    o_ERR_CHECKSUM,
  output logic                    o_ERR_LENGTH,
  output logic                    o_ERR_TIMEOUT,
  output logic                    o_OVERRUN
);

  localparam int unsigned c_DEPTH = 2**c_ADDR_WIDTH;
  localparam int unsigned c_IW    = c_ADDR_WIDTH + 1;
  localparam int unsigned c_TW    = $clog2(c_TIMEOUT_CYCLES);
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(c_TIMEOUT_CYCLES - 1);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] LEN     = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] CSUM    = 3'd4;
  localparam logic [2:0] HOLD    = 3'd5;

  logic [2:0]      r_state, w_nxt_state;
  logic [7:0]      r_cmd, w_nxt_cmd;
  logic [7:0]      r_len, w_nxt_len;
  logic [7:0]      r_xor, w_nxt_xor;
  logic [c_IW-1:0] r_idx, w_nxt_idx;
  logic [c_TW-1:0] r_tcnt, w_nxt_tcnt;
  logic            r_frame_valid, w_nxt_frame_valid;
  logic [7:0]      r_out_cmd, w_nxt_out_cmd;
  logic [7:0]      r_out_len, w_nxt_out_len;
  logic            r_err_csum, w_nxt_err_csum;
  logic            r_err_len, w_nxt_err_len;
  logic            r_err_to, w_nxt_err_to;
  logic            r_overrun, w_nxt_overrun;
  logic            w_we;
  logic            w_active;
  logic            w_timeout;
  logic [7:0]      r_mem [0:c_DEPTH-1];
  logic [7:0]      r_rd_data;

  // Inter-byte timer runs only while a frame is being collected.
  assign w_active  = (r_state == CMD) || (r_state == LEN) ||
                     (r_state == PAYLOAD) || (r_state == CSUM);
  assign w_timeout = w_active && !i_RX_DATA_VALID && (r_tcnt == c_TMAX);

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cmd         = r_cmd;
    w_nxt_len         = r_len;
    w_nxt_xor         = r_xor;
    w_nxt_idx         = r_idx;
    w_nxt_tcnt        = '0;
    w_nxt_frame_valid = r_frame_valid;
    w_nxt_out_cmd     = r_out_cmd;
    w_nxt_out_len     = r_out_len;
    w_nxt_err_csum    = 1'b0;
    w_nxt_err_len     = 1'b0;
    w_nxt_err_to      = 1'b0;
    w_nxt_overrun     = 1'b0;
    w_we              = 1'b0;

    if (w_active && !i_RX_DATA_VALID && !w_timeout) begin
      w_nxt_tcnt = r_tcnt + c_TW'(1);
    end

    case (r_state)
      HUNT: begin
        if (i_RX_DATA_VALID && (i_DATA_RX == c_SYNC_BYTE)) w_nxt_state = CMD;
      end
      CMD: begin
        if (i_RX_DATA_VALID) begin
          w_nxt_cmd   = i_DATA_RX;
          w_nxt_xor   = i_DATA_RX;
          w_nxt_state = LEN;
        end
      end
      LEN: begin
        if (i_RX_DATA_VALID) begin
          if (i_DATA_RX > 8'(c_MAX_PAYLOAD)) begin
            w_nxt_err_len = 1'b1;
            w_nxt_state   = HUNT;
          end else begin
            w_nxt_len   = i_DATA_RX;
            w_nxt_xor   = r_xor ^ i_DATA_RX;
            w_nxt_idx   = '0;
            w_nxt_state = (i_DATA_RX == 8'd0) ? CSUM : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (i_RX_DATA_VALID) begin
          w_we      = 1'b1;
          w_nxt_xor = r_xor ^ i_DATA_RX;
          w_nxt_idx = r_idx + c_IW'(1);
          // Index is one bit wider than the address, so a full buffer never wraps here.
          if ((8'(r_idx) + 8'd1) == r_len) w_nxt_state = CSUM;
        end
      end
      CSUM: begin
        if (i_RX_DATA_VALID) begin
          if (i_DATA_RX == r_xor) begin
            w_nxt_state       = HOLD;
            w_nxt_frame_valid = 1'b1;
            w_nxt_out_cmd     = r_cmd;
            w_nxt_out_len     = r_len;
          end else begin
            w_nxt_err_csum = 1'b1;
            w_nxt_state    = HUNT;
          end
        end
      end
      HOLD: begin
        if (i_FRAME_ACK) begin
          // A byte coinciding with the ack is treated as if already hunting.
          w_nxt_frame_valid = 1'b0;
          w_nxt_out_cmd     = 8'd0;
          w_nxt_out_len     = 8'd0;
          w_nxt_state = (i_RX_DATA_VALID && (i_DATA_RX == c_SYNC_BYTE)) ? CMD : HUNT;
        end else if (i_RX_DATA_VALID) begin
          w_nxt_overrun = 1'b1;
        end
      end
      default: w_nxt_state = HUNT;
    endcase

    if (w_timeout) begin
      w_nxt_state  = HUNT;
      w_nxt_err_to = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state       <= HUNT;
      r_cmd         <= 8'd0;
      r_len         <= 8'd0;
      r_xor         <= 8'd0;
      r_idx         <= '0;
      r_tcnt        <= '0;
      r_frame_valid <= 1'b0;
      r_out_cmd     <= 8'd0;
      r_out_len     <= 8'd0;
      r_err_csum    <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_to      <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cmd         <= w_nxt_cmd;
      r_len         <= w_nxt_len;
      r_xor         <= w_nxt_xor;
      r_idx         <= w_nxt_idx;
      r_tcnt        <= w_nxt_tcnt;
      r_frame_valid <= w_nxt_frame_valid;
      r_out_cmd     <= w_nxt_out_cmd;
      r_out_len     <= w_nxt_out_len;
      r_err_csum    <= w_nxt_err_csum;
      r_err_len     <= w_nxt_err_len;
      r_err_to      <= w_nxt_err_to;
      r_overrun     <= w_nxt_overrun;
    end
  end

  // Payload buffer and registered read port; intentionally not reset.
  always_ff @(posedge i_CLK) begin
    if (w_we) r_mem[r_idx[c_ADDR_WIDTH-1:0]] <= i_DATA_RX;
    r_rd_data <= r_mem[i_RD_ADDR];
  end

  assign o_RD_DATA      = r_rd_data;
  assign o_FRAME_VALID  = r_frame_valid;
  assign o_CMD          = r_out_cmd;
  assign o_LEN          = r_out_len;
  assign o_ERR_CHECKSUM = r_err_csum;
  assign o_ERR_LENGTH   = r_err_len;
  assign o_ERR_TIMEOUT  = r_err_to;
  assign o_OVERRUN      = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frames plus randomized frames
// checked against a frame-level reference model built in the bench.
module tb_uart_rx_frame_ctrl;

  typedef logic [7:0] byte_q_t [$];

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       fv;
  logic [7:0] cmd;
  logic [7:0] len;
  logic       e_cs, e_ln, e_to, ovr;

  int total = 0;
  int bad   = 0;
  int cnt_cs = 0, cnt_ln = 0, cnt_to = 0, cnt_ov = 0;

  uart_rx_frame_ctrl dut (
    .i_CLK          (clk),
    .i_RST          (rst),
    .i_DATA_RX      (data),
    .i_RX_DATA_VALID(valid),
    .i_FRAME_ACK    (ack),
    .i_RD_ADDR      (rd_addr),
    .o_RD_DATA      (rd_data),
    .o_FRAME_VALID  (fv),
    .o_CMD          (cmd),
    .o_LEN          (len),
    .o_ERR_CHECKSUM (e_cs),
    .o_ERR_LENGTH   (e_ln),
    .o_ERR_TIMEOUT  (e_to),
    .o_OVERRUN      (ovr)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Count every high cycle of each pulse output.
  always @(negedge clk) begin
    if (!rst) begin
      cnt_cs <= cnt_cs + int'(e_cs);
      cnt_ln <= cnt_ln + int'(e_ln);
      cnt_to <= cnt_to + int'(e_to);
      cnt_ov <= cnt_ov + int'(ovr);
    end
  end

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [7:0] garb();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h3C;
    return b;
  endfunction

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    data = b; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_seq(input byte_q_t q);
    foreach (q[i]) send_byte(q[i], (i == q.size() - 1) ? 0 : $urandom_range(0, 40));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if (fv !== 1'b0) begin bad++; $display("FAIL ack_release: fv=%0b want 0", fv); end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; ack = 1'b0; data = 8'd0; rd_addr = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({fv, cmd, len, e_cs, e_ln, e_to, ovr} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs: got fv=%0b cmd=%0h len=%0h errs=%b want all 0",
                      fv, cmd, len, {e_cs, e_ln, e_to, ovr});
    end
  endtask

  task automatic test_good_frame();
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    total++;
    if ({fv, cmd, len} !== {1'b1, 8'h10, 8'h03}) begin
      bad++; $display("FAIL case1_frame: fv=%0b cmd=%0h len=%0h want 1 10 03", fv, cmd, len);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33;
      rd_addr = 3'(i);
      tick();
      total++;
      if (rd_data !== exp_b) begin
        bad++; $display("FAIL case1_read%0d: got %0h want %0h", i, rd_data, exp_b);
      end
    end
    do_ack();
  endtask

  task automatic test_garbage_zero_len();
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h42, 8'h00, 8'h42});
    total++;
    if ({fv, cmd, len} !== {1'b1, 8'h42, 8'h00}) begin
      bad++; $display("FAIL case2_frame: fv=%0b cmd=%0h len=%0h want 1 42 00", fv, cmd, len);
    end
    do_ack();
  endtask

  task automatic test_checksum_err();
    int c0;
    c0 = cnt_cs;
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14});
    tick(); tick();
    total++;
    if ({fv, 8'(cnt_cs - c0)} !== {1'b0, 8'd1}) begin
      bad++; $display("FAIL case3_csum: fv=%0b pulses=%0d want fv 0 pulses 1", fv, cnt_cs - c0);
    end
    test_good_frame();
  endtask

  task automatic test_length_err();
    int c0, o0;
    c0 = cnt_ln; o0 = cnt_cs + cnt_to + cnt_ov;
    send_seq('{8'hA5, 8'h10, 8'h09, 8'h01, 8'h02});
    tick(); tick();
    total++;
    if ({fv, 8'(cnt_ln - c0), 8'(cnt_cs + cnt_to + cnt_ov - o0)} !== {1'b0, 8'd1, 8'd0}) begin
      bad++; $display("FAIL case4_len: fv=%0b len_pulses=%0d other=%0d want 0 1 0",
                      fv, cnt_ln - c0, cnt_cs + cnt_to + cnt_ov - o0);
    end
  endtask

  task automatic test_timeout();
    int hits, at, t0;
    hits = 0; at = 0; t0 = cnt_to;
    send_seq('{8'hA5, 8'h10});
    for (int k = 1; k <= 5000; k++) begin
      tick();
      if (e_to) begin
        hits++;
        if (at == 0) at = k;
      end
    end
    total++;
    if (hits != 1) begin bad++; $display("FAIL timeout_count: got %0d want 1", hits); end
    total++;
    if (at < 4339 || at > 4341) begin
      bad++; $display("FAIL timeout_latency: got %0d cycles want 4339..4341", at);
    end
    // Rest of the discarded frame must not complete anything.
    send_seq('{8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    total++;
    if (fv !== 1'b0) begin bad++; $display("FAIL timeout_discard: fv=%0b want 0", fv); end
    test_good_frame();
    // A long but legal gap must not time out.
    t0 = cnt_to;
    send_byte(8'hA5, 3);
    send_byte(8'h10, 4000);
    send_seq('{8'h01, 8'h55, 8'h44});
    tick();
    total++;
    if ({fv, cmd, 8'(cnt_to - t0)} !== {1'b1, 8'h10, 8'd0}) begin
      bad++; $display("FAIL near_timeout: fv=%0b cmd=%0h to_pulses=%0d want 1 10 0",
                      fv, cmd, cnt_to - t0);
    end
    do_ack();
  endtask

  task automatic test_overrun_reset();
    int o0;
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
    o0 = cnt_ov;
    send_byte(8'h55, 2);
    total++;
    if ({fv, cmd, len, 8'(cnt_ov - o0)} !== {1'b1, 8'h10, 8'h03, 8'd1}) begin
      bad++; $display("FAIL overrun: fv=%0b cmd=%0h len=%0h pulses=%0d want 1 10 03 1",
                      fv, cmd, len, cnt_ov - o0);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33;
      rd_addr = 3'(i);
      tick();
      total++;
      if (rd_data !== exp_b) begin
        bad++; $display("FAIL overrun_ram%0d: got %0h want %0h", i, rd_data, exp_b);
      end
    end
    // Ack together with a sync byte starts the next frame immediately.
    ack = 1'b1; data = 8'hA5; valid = 1'b1;
    tick();
    ack = 1'b0; valid = 1'b0;
    total++;
    if (fv !== 1'b0) begin bad++; $display("FAIL ack_with_sync_release: fv=%0b want 0", fv); end
    send_seq('{8'h20, 8'h00, 8'h20});
    total++;
    if ({fv, cmd, len} !== {1'b1, 8'h20, 8'h00}) begin
      bad++; $display("FAIL ack_with_sync_frame: fv=%0b cmd=%0h len=%0h want 1 20 00", fv, cmd, len);
    end
    // Reset while holding a frame.
    rst = 1'b1; #1;
    total++;
    if ({fv, cmd, len, e_cs, e_ln, e_to, ovr} !== 21'd0) begin
      bad++; $display("FAIL reset_hold: fv=%0b cmd=%0h len=%0h want 0", fv, cmd, len);
    end
    tick(); rst = 1'b0; tick();
    // Reset mid-payload: remaining bytes must be ignored.
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
    rst = 1'b1; #1;
    total++;
    if ({fv, cmd, len, e_cs, e_ln, e_to, ovr} !== 21'd0) begin
      bad++; $display("FAIL reset_mid: fv=%0b cmd=%0h len=%0h want 0", fv, cmd, len);
    end
    tick(); rst = 1'b0; tick();
    o0 = cnt_cs + cnt_ln + cnt_to + cnt_ov;
    send_seq('{8'h22, 8'h33, 8'h13});
    tick(); tick();
    total++;
    if ({fv, 8'(cnt_cs + cnt_ln + cnt_to + cnt_ov - o0)} !== {1'b0, 8'd0}) begin
      bad++; $display("FAIL reset_discard: fv=%0b pulses=%0d want 0 0",
                      fv, cnt_cs + cnt_ln + cnt_to + cnt_ov - o0);
    end
    test_good_frame();
  endtask

  // kind: 0 good frame, 1 corrupted checksum, 2 oversized LEN.
  task automatic run_random_frame(input int unsigned kind, input int unsigned plen_in,
                                  input bit tight, input string tag);
    byte_q_t    q;
    logic [7:0] pl [8];
    logic [7:0] cmd_b, len_b, x;
    int unsigned plen;
    int c_cs, c_ln, c_to, c_ov;
    plen  = (kind == 2) ? 0 : plen_in;
    cmd_b = 8'($urandom);
    len_b = (kind == 2) ? 8'($urandom_range(9, 255)) : 8'(plen);
    q = {};
    repeat ($urandom_range(0, 3)) q.push_back(garb());
    q.push_back(8'hA5); q.push_back(cmd_b); q.push_back(len_b);
    x = cmd_b ^ len_b;
    for (int i = 0; i < int'(plen); i++) begin
      pl[i] = 8'($urandom);
      q.push_back(pl[i]);
      x = x ^ pl[i];
    end
    if (kind == 0) q.push_back(x);
    else if (kind == 1) q.push_back(x ^ 8'($urandom_range(1, 255)));
    else begin q.push_back(garb()); q.push_back(garb()); end
    c_cs = cnt_cs; c_ln = cnt_ln; c_to = cnt_to; c_ov = cnt_ov;
    if (tight) foreach (q[i]) send_byte(q[i], 0);
    else send_seq(q);
    total++;
    if (fv !== (kind == 0)) begin
      bad++; $display("FAIL %s_valid: kind=%0d fv=%0b want %0b", tag, kind, fv, kind == 0);
    end
    if (kind == 0) begin
      total++;
      if ({cmd, len} !== {cmd_b, len_b}) begin
        bad++; $display("FAIL %s_hdr: cmd=%0h len=%0h want %0h %0h", tag, cmd, len, cmd_b, len_b);
      end
      for (int i = 0; i < int'(plen); i++) begin
        rd_addr = 3'(i);
        tick();
        total++;
        if (rd_data !== pl[i]) begin
          bad++; $display("FAIL %s_ram%0d: got %0h want %0h", tag, i, rd_data, pl[i]);
        end
      end
    end
    tick(); tick();
    total++;
    if ({8'(cnt_cs - c_cs), 8'(cnt_ln - c_ln), 8'(cnt_to - c_to), 8'(cnt_ov - c_ov)} !==
        {8'(kind == 1), 8'(kind == 2), 8'd0, 8'd0}) begin
      bad++; $display("FAIL %s_pulses: kind=%0d cs=%0d ln=%0d to=%0d ov=%0d", tag, kind,
                      cnt_cs - c_cs, cnt_ln - c_ln, cnt_to - c_to, cnt_ov - c_ov);
    end
    if (kind == 0) do_ack();
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 24; n++) begin
      run_random_frame($urandom_range(0, 2), $urandom_range(0, 8), 1'b0, "rand");
    end
  endtask

  task automatic test_back_to_back();
    run_random_frame(1, 8, 1'b1, "b2b_bad");
    run_random_frame(0, 8, 1'b1, "b2b_full");
    run_random_frame(2, 0, 1'b1, "b2b_len");
    run_random_frame(0, 1, 1'b1, "b2b_one");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_garbage_zero_len();
    test_checksum_err();
    test_length_err();
    test_timeout();
    test_overrun_reset();
    test_random_frames();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
